// File: rtl/uart_frame_rx.sv
// UART frame receiver: start bit, FRAME_WD data bits LSB first, optional parity, one stop bit.
// Optional build macro UART_RX_MAJORITY_EN selects a 2-of-3 majority vote around each sample point.
module uart_frame_rx #(
  parameter int    CLK_FREQUENCE = 50_000_000,
  parameter int    BAUD_RATE     = 9600,
  parameter string PARITY        = "NONE",
  parameter int    FRAME_WD      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rx,
  output logic [FRAME_WD-1:0] data_frame,
  output logic                rx_done,
  output logic                parity_error,
  output logic                frame_error
);

  localparam int BIT_CNT = CLK_FREQUENCE / BAUD_RATE;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT + 1);
  localparam int IW      = $clog2(FRAME_WD);
  localparam bit PAR_EN  = (PARITY != "NONE");
  localparam bit PAR_ODD = (PARITY == "ODD");
`ifdef UART_RX_MAJORITY_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif
  localparam logic [CW-1:0] START_PT = CW'(HALF - 1 + LAG);
  localparam logic [CW-1:0] BIT_PT   = CW'(BIT_CNT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_WD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [FRAME_WD-1:0] shreg;
  logic                par_err;
  logic                rx_m;
  logic                rx_s;
  logic                rx_d;
  logic                bit_v;

`ifdef UART_RX_MAJORITY_EN
  logic rx_d2;

  // synchronizer plus two history taps for the vote and edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_m  <= uart_rx;
      rx_s  <= rx_m;
      rx_d  <= rx_s;
      rx_d2 <= rx_d;
    end
  end

  // decision one cycle after the sample point: taps hold -1, 0, +1
  always_comb begin
    bit_v = (rx_s & rx_d) | (rx_s & rx_d2) | (rx_d & rx_d2);
  end
`else
  // synchronizer plus one history tap for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // single sample at the sample point
  always_comb begin
    bit_v = rx_s;
  end
`endif

  // frame FSM with registered strobes and data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      par_err      <= 1'b0;
      data_frame   <= '0;
      rx_done      <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_done      <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (rx_d && !rx_s) begin
            state   <= S_START;
            idx     <= '0;
            par_err <= 1'b0;
          end
        end
        S_START: begin
          if (cnt == START_PT) begin
            cnt   <= '0;
            state <= bit_v ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_PT) begin
            cnt   <= '0;
            shreg <= {bit_v, shreg[FRAME_WD-1:1]};
            idx   <= idx + 1'b1;
            if (idx == IDX_LAST) begin
              state <= PAR_EN ? S_PAR : S_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PAR: begin
          if (cnt == BIT_PT) begin
            cnt     <= '0;
            par_err <= (^shreg) ^ bit_v ^ PAR_ODD;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_PT) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (bit_v) begin
              data_frame   <= shreg;
              rx_done      <= 1'b1;
              parity_error <= PAR_EN & par_err;
            end else begin
              frame_error <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: good frames, back-to-back,
// parity, framing error/break, glitches and mid-frame reset.
module tb_uart_frame_rx;

  localparam int CLK_F = 1_600_000;
  localparam int BAUD  = 100_000;
  localparam int B     = CLK_F / BAUD;
  localparam int HALF  = B / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int LAT = 3 + (HALF - 1) + 9 * B + 1 + MAJ;

  logic       clk = 1'b0;
  logic       rst;
  logic       line_a;
  logic       line_p;
  logic [7:0] data_a, data_e, data_o;
  logic       done_a, done_e, done_o;
  logic       pe_a, pe_e, pe_o;
  logic       fe_a, fe_e, fe_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int t_a = 0;
  int t_prev_a = 0;
  int dn_a = 0;
  int fe_n_a = 0;
  int pe_n_a = 0;
  int dn_e = 0;
  int dn_o = 0;
  int fe_n_p = 0;
  logic pe_e_last = 1'b0;
  logic pe_o_last = 1'b0;
  logic [7:0] q_a[$];
  int ea;

  uart_frame_rx #(
    .CLK_FREQUENCE(CLK_F), .BAUD_RATE(BAUD),
    .PARITY("NONE"), .FRAME_WD(8)
  ) u_a (
    .clk(clk), .rst(rst), .uart_rx(line_a),
    .data_frame(data_a), .rx_done(done_a),
    .parity_error(pe_a), .frame_error(fe_a)
  );

  uart_frame_rx #(
    .CLK_FREQUENCE(CLK_F), .BAUD_RATE(BAUD),
    .PARITY("EVEN"), .FRAME_WD(8)
  ) u_e (
    .clk(clk), .rst(rst), .uart_rx(line_p),
    .data_frame(data_e), .rx_done(done_e),
    .parity_error(pe_e), .frame_error(fe_e)
  );

  uart_frame_rx #(
    .CLK_FREQUENCE(CLK_F), .BAUD_RATE(BAUD),
    .PARITY("ODD"), .FRAME_WD(8)
  ) u_o (
    .clk(clk), .rst(rst), .uart_rx(line_p),
    .data_frame(data_o), .rx_done(done_o),
    .parity_error(pe_o), .frame_error(fe_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_a) begin
      dn_a++;
      q_a.push_back(data_a);
      t_prev_a = t_a;
      t_a = cyc;
      if (pe_a) pe_n_a++;
    end
    if (fe_a) fe_n_a++;
    if (done_e) begin
      dn_e++;
      pe_e_last = pe_e;
    end
    if (done_o) begin
      dn_o++;
      pe_o_last = pe_o;
    end
    if (fe_e || fe_o) fe_n_p++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) line_p = v;
    else line_a = v;
  endtask

  task automatic send(input bit sel, input logic [8:0] d, input bit has_par,
                      input bit par, input bit stop, input int gl);
    drive(sel, 1'b0);
    t0 = cyc;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      if (i == gl) begin
        repeat (HALF) @(negedge clk);
        drive(sel, 1'b1);
        @(negedge clk);
        drive(sel, d[i]);
        repeat (B - HALF - 1) @(negedge clk);
      end else begin
        repeat (B) @(negedge clk);
      end
    end
    if (has_par) begin
      drive(sel, par);
      repeat (B) @(negedge clk);
    end
    drive(sel, stop);
    repeat (B) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    line_a = 1'b1;
    line_p = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", data_a, 8'h00);
    chk("rst_done", done_a, 1'b0);
    chk("rst_perr", pe_a, 1'b0);
    chk("rst_ferr", fe_a, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send(1'b0, 9'h02B, 1'b0, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    ea = 1;
    chk("good_cnt", dn_a, ea);
    chk("good_data", data_a, 8'h2B);
    chk("good_perr", pe_n_a, 0);
    chk("good_ferr", fe_n_a, 0);
    chk("good_lat", t_a - t0, LAT);

    send(1'b0, 9'h035, 1'b0, 1'b0, 1'b0, -1);
    repeat (4) @(negedge clk);
    chk("ferr_cnt", fe_n_a, 1);
    chk("ferr_nodone", dn_a, ea);
    chk("ferr_hold", data_a, 8'h2B);
    repeat (30 * B) @(negedge clk);
    chk("break_ferr", fe_n_a, 1);
    chk("break_done", dn_a, ea);
    line_a = 1'b1;
    repeat (2 * B) @(negedge clk);
    send(1'b0, 9'h0A5, 1'b0, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    ea++;
    chk("post_brk_cnt", dn_a, ea);
    chk("post_brk_data", data_a, 8'hA5);

    send(1'b0, 9'h02B, 1'b0, 1'b0, 1'b1, -1);
    send(1'b0, 9'h035, 1'b0, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    ea += 2;
    chk("b2b_cnt", dn_a, ea);
    chk("b2b_first", q_a[2], 8'h2B);
    chk("b2b_second", q_a[3], 8'h35);
    chk("b2b_gap", t_a - t_prev_a, 10 * B);

    line_a = 1'b0;
    repeat (5) @(negedge clk);
    line_a = 1'b1;
    repeat (3 * B) @(negedge clk);
    chk("glitch_done", dn_a, ea);
    chk("glitch_ferr", fe_n_a, 1);

`ifdef UART_RX_MAJORITY_EN
    send(1'b0, 9'h02B, 1'b0, 1'b0, 1'b1, 2);
    repeat (4) @(negedge clk);
    ea++;
    chk("maj_cnt", dn_a, ea);
    chk("maj_data", data_a, 8'h2B);
`endif

    send(1'b1, 9'h02B, 1'b1, 1'b1, 1'b1, -1);
    repeat (4) @(negedge clk);
    chk("par1_even_cnt", dn_e, 1);
    chk("par1_even_err", pe_e_last, 1'b1);
    chk("par1_even_data", data_e, 8'h2B);
    chk("par1_odd_cnt", dn_o, 1);
    chk("par1_odd_err", pe_o_last, 1'b0);
    send(1'b1, 9'h02B, 1'b1, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    chk("par0_even_cnt", dn_e, 2);
    chk("par0_even_err", pe_e_last, 1'b0);
    chk("par0_odd_err", pe_o_last, 1'b1);
    chk("par_ferr", fe_n_p, 0);
    chk("none_perr", pe_n_a, 0);

    line_a = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      line_a = i[0];
      repeat (B) @(negedge clk);
    end
    line_a = 1'b1;
    repeat (HALF) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", data_a, 8'h00);
    chk("mid_rst_done", done_a, 1'b0);
    chk("mid_rst_ferr", fe_a, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10 * B) @(negedge clk);
    chk("mid_rst_nostrobe", dn_a, ea);
    chk("mid_rst_noferr", fe_n_a, 1);
    send(1'b0, 9'h00F, 1'b0, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    ea++;
    chk("after_rst_cnt", dn_a, ea);
    chk("after_rst_data", data_a, 8'h0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

UART frame receiver, the receive-side counterpart of the team's `UART_tx` frame transmitter, sharing its parameter set and frame format (start bit, `FRAME_WD` data bits LSB first, optional parity, one stop bit). It recovers frames from the serial line `uart_rx` and presents each one on `data_frame` with a one-cycle `rx_done` strobe. Framing and parity errors are flagged on the same strobe cycle. It sits between the board-level RX pin and downstream frame consumers.

## Interface
- `CLK_FREQUENCE`, 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s. `BIT_CNT = CLK_FREQUENCE/BAUD_RATE` (integer division). `HALF = BIT_CNT/2`.
- `PARITY`, "NONE": "NONE", "EVEN" or "ODD".
- `FRAME_WD`, 8: data bits per frame, 5..9.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `uart_rx` in 1: serial line, idle high, asynchronous to `clk`.
- `data_frame` out `FRAME_WD`: last received data, LSB = first data bit on the line.
- `rx_done` out 1: one-cycle strobe, frame accepted.
- `parity_error` out 1: valid only while `rx_done` is high. Always 0 when `PARITY`="NONE".
- `frame_error` out 1: one-cycle strobe, stop bit sampled low.

## Operation
- Input conditioning: a 2-flop synchronizer drives `rx_s`. Both flops reset to 1.
- Bit-period counter `cnt` runs 0..BIT_CNT-1, is cleared on every state entry, and wraps at BIT_CNT-1.
- IDLE: waits for a falling edge on `rx_s` (previous 1, current 0), then enters START.
- START: samples at `cnt`==HALF-1.
  - Sample 0 goes to DATA.
  - Sample 1 is a false start; return to IDLE with no strobe.
- DATA:
  - Samples FRAME_WD bits, one per BIT_CNT cycles, measured from the start-bit sample point.
  - Each bit shifts in at MSB of a shift register, so the first received bit ends at LSB.
  - A bit index 0..FRAME_WD-1 tracks position.
  - After the last bit, go to PARITY if `PARITY`≠"NONE", otherwise to STOP.
- PARITY: samples one bit. Parity error is computed as:
  - EVEN: XOR(data, p) ≠ 0.
  - ODD: XOR(data, p) ≠ 1.
  - The flag is held internally until STOP.
- STOP: samples one bit, then always returns to IDLE.
  - Sample 1: `data_frame` ← shift register, `rx_done`=1 and `parity_error`=held flag, both for one cycle.
  - Sample 0: `frame_error`=1 for one cycle. `data_frame` is unchanged, `rx_done` stays 0, `parity_error` stays 0.
- Break condition (line held low): after a `frame_error`, no new frame starts until `rx_s` returns high and falls again. One `frame_error` per break, not repeated.
- Back-to-back frames: the return to IDLE happens at mid stop bit, so a start edge directly after the stop bit is caught.
- Reset mid-frame: state goes to IDLE immediately, the partial frame is discarded, and no strobe is produced.
- `uart_rx` transitions between sample points are ignored (no resynchronisation within a frame).

## Timing
- Reset values: `data_frame`=0, `rx_done`=0, `parity_error`=0, `frame_error`=0, state IDLE, synchronizer 1.
- Start detect: `uart_rx` fall to IDLE→START transition takes 3 `clk` cycles (2 synchronizer stages plus edge register).
- Sample point k (k=0 is the start bit) occurs at START entry + HALF-1 + k·BIT_CNT cycles.
- `rx_done`, `frame_error` and the `data_frame` update are registered: they appear 1 cycle after the stop-bit sample.
- All outputs are registered. `data_frame` holds its value until the next good frame.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - Defined: each bit is the 2-of-3 majority of `rx_s` at sample point −1, 0 and +1. The decision is taken at +1, so every decision and every strobe moves 1 cycle later. A start bit with a majority of 1 is a false start.
  - Undefined: single sample at the sample point.

## Test plan
- Good frame, 50 MHz / 9600 baud (BIT_CNT=5208), 8N1, byte 8'h2B → one `rx_done` pulse, `data_frame`=8'h2B, both error flags 0, strobe ≈ 3+2603+9·5208+1 cycles after the start edge.
- Two back-to-back frames 8'h2B then 8'h35, no idle gap → two `rx_done` pulses 10·5208 cycles apart, `data_frame` 8'h2B then 8'h35.
- `PARITY`="EVEN", 8'h2B sent with wrong parity bit 1 → `rx_done`=1 with `parity_error`=1, `data_frame`=8'h2B. Correct parity bit 0 → `parity_error`=0.
- Stop bit forced 0 on 8'h35 → `frame_error` pulse, no `rx_done`, `data_frame` keeps its previous value. Line then held low for 30 bit-times → no further strobes. Release, then a good 8'hA5 → received correctly.
- 1000-cycle low glitch in IDLE → no strobe, state back to IDLE. With `UART_RX_MAJORITY_EN`, a 1-cycle high glitch on a data-bit sample point → bit still decoded correctly.
- `rst` asserted during data bit 4 → outputs at reset values immediately, no strobe. The next full frame 8'h0F after release → `data_frame`=8'h0F.
